// File: rtl/dtree_walk_engine.sv
// rtl/dtree_walk_engine.sv - run-time programmable decision-tree walker, one node per clock
// Optional decision-path output enabled by defining DTREE_PATH_EN.
module dtree_walk_engine #(
    parameter int N_FEAT    = 51,
    parameter int IDX_W     = 6,
    parameter int NODE_AW   = 6,
    parameter int CLASS_W   = 1,
    parameter int MAX_DEPTH = 16,
    parameter int NODE_W    = 1 + CLASS_W + IDX_W + 2 * NODE_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [NODE_AW-1:0]   cfg_addr,
    input  logic [NODE_W-1:0]    cfg_data,
    output logic                 cfg_ready,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_FEAT-1:0]    in_feat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CLASS_W-1:0]   out_class,
    output logic                 out_err
`ifdef DTREE_PATH_EN
    ,
    output logic [MAX_DEPTH-1:0] out_path
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WALK = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEPTH_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam int FEXT_W  = 2 ** IDX_W;

    logic [1:0]          state;
    logic [NODE_W-1:0]   node_mem [2**NODE_AW];
    logic [NODE_AW-1:0]  ptr;
    logic [DEPTH_W-1:0]  depth;
    logic [N_FEAT-1:0]   feat_q;
    logic [CLASS_W-1:0]  class_q;
    logic                err_q;

    logic [NODE_W-1:0]   node;
    logic                n_leaf;
    logic [CLASS_W-1:0]  n_class;
    logic [IDX_W-1:0]    n_idx;
    logic [NODE_AW-1:0]  n_hi;
    logic [NODE_AW-1:0]  n_lo;
    logic [FEXT_W-1:0]   feat_ext;
    logic                feat_bit;
    logic                last_level;

    assign cfg_ready = (state == ST_IDLE);
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign out_class = class_q;
    assign out_err   = err_q;

    // Asynchronous table read; entry = {leaf, class, feat_idx, hi_ptr, lo_ptr}
    assign node    = node_mem[ptr];
    assign n_leaf  = node[NODE_W-1];
    assign n_class = node[NODE_W-2 -: CLASS_W];
    assign n_idx   = node[2*NODE_AW +: IDX_W];
    assign n_hi    = node[NODE_AW +: NODE_AW];
    assign n_lo    = node[0 +: NODE_AW];

    // Zero-extension makes any feat_idx beyond N_FEAT read as 0
    assign feat_ext   = FEXT_W'(feat_q);
    assign feat_bit   = feat_ext[n_idx];
    assign last_level = (depth == DEPTH_W'(MAX_DEPTH - 1));

    // Table has no reset so a programmed tree survives rst
    always_ff @(posedge clk) begin
        if (cfg_we && (state == ST_IDLE))
            node_mem[cfg_addr] <= cfg_data;
    end

`ifdef DTREE_PATH_EN
    logic [MAX_DEPTH-1:0] path_q;
    assign out_path = path_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            path_q <= '0;
        end else if ((state == ST_IDLE) && in_valid) begin
            path_q <= '0;
        end else if ((state == ST_WALK) && !n_leaf && !last_level) begin
            path_q[depth] <= feat_bit;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            depth   <= '0;
            feat_q  <= '0;
            class_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        feat_q <= in_feat;
                        ptr    <= '0;
                        depth  <= '0;
                        state  <= ST_WALK;
                    end
                end
                ST_WALK: begin
                    if (n_leaf) begin
                        class_q <= n_class;
                        err_q   <= 1'b0;
                        state   <= ST_DONE;
                    end else if (last_level) begin
                        class_q <= '0;
                        err_q   <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        ptr   <= feat_bit ? n_hi : n_lo;
                        depth <= depth + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dtree_walk_engine.sv
// tb/tb_dtree_walk_engine.sv - directed self-checking bench for dtree_walk_engine
// Path checks are compiled in only when DTREE_PATH_EN is defined.
module tb_dtree_walk_engine;

    localparam int N_FEAT    = 51;
    localparam int IDX_W     = 6;
    localparam int NODE_AW   = 6;
    localparam int CLASS_W   = 1;
    localparam int MAX_DEPTH = 16;
    localparam int NODE_W    = 1 + CLASS_W + IDX_W + 2 * NODE_AW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cfg_we = 1'b0;
    logic [NODE_AW-1:0]   cfg_addr = '0;
    logic [NODE_W-1:0]    cfg_data = '0;
    logic                 cfg_ready;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [N_FEAT-1:0]    in_feat = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [CLASS_W-1:0]   out_class;
    logic                 out_err;
`ifdef DTREE_PATH_EN
    logic [MAX_DEPTH-1:0] out_path;
`endif

    int errors = 0;
    int checks = 0;
    int edges;
    logic [N_FEAT-1:0] f1;
    logic [N_FEAT-1:0] f2;

    dtree_walk_engine dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feat   (in_feat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_err   (out_err)
`ifdef DTREE_PATH_EN
        ,
        .out_path  (out_path)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_node(input int addr, input logic leaf, input logic cls,
                              input int idx, input int hi, input int lo);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = NODE_AW'(addr);
        cfg_data = {leaf, cls, IDX_W'(idx), NODE_AW'(hi), NODE_AW'(lo)};
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_walk(input logic [N_FEAT-1:0] f, output int n);
        @(negedge clk);
        chk("accept_in_ready", {31'd0, in_ready}, 32'd1);
        in_feat  = f;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        f1 = '0; f1[10] = 1'b1; f1[40] = 1'b1;
        f2 = '0; f2[40] = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_class", {31'd0, out_class}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
`ifdef DTREE_PATH_EN
        chk("rst_out_path", {16'd0, out_path}, 32'd0);
`endif

        write_node(0, 1'b0, 1'b0, 10, 1, 2);
        write_node(1, 1'b0, 1'b0, 40, 3, 2);
        write_node(2, 1'b1, 1'b0, 0, 0, 0);
        write_node(3, 1'b1, 1'b1, 0, 0, 0);

        // Scenario 1: N0 -> N1 -> N3, leaf at depth 2
        run_walk(f1, edges);
        chk("s1_latency", edges, 32'd3);
        chk("s1_class", {31'd0, out_class}, 32'd1);
        chk("s1_err", {31'd0, out_err}, 32'd0);
`ifdef DTREE_PATH_EN
        chk("s1_path", {16'd0, out_path}, 32'h0003);
`endif
        release_result();

        // Scenario 2: N0 -> N2, leaf at depth 1
        run_walk(f2, edges);
        chk("s2_latency", edges, 32'd2);
        chk("s2_class", {31'd0, out_class}, 32'd0);
        chk("s2_err", {31'd0, out_err}, 32'd0);
`ifdef DTREE_PATH_EN
        chk("s2_path", {16'd0, out_path}, 32'd0);
`endif
        release_result();

        // Scenario 4: backpressure in DONE
        run_walk(f1, edges);
        chk("s4_latency", edges, 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s4_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("s4_hold_class", {31'd0, out_class}, 32'd1);
            chk("s4_hold_err", {31'd0, out_err}, 32'd0);
            chk("s4_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        release_result();

        // Scenario 5: config write attempted during WALK is ignored
        @(negedge clk);
        in_feat  = f1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("s5_cfg_ready_walk", {31'd0, cfg_ready}, 32'd0);
        cfg_we   = 1'b1;
        cfg_addr = NODE_AW'(3);
        cfg_data = {1'b1, 1'b0, IDX_W'(0), NODE_AW'(0), NODE_AW'(0)};
        @(posedge clk);
        @(negedge clk);
        cfg_we = 1'b0;
        wait_done(edges);
        chk("s5_class_during", {31'd0, out_class}, 32'd1);
        release_result();
        run_walk(f1, edges);
        chk("s5_class_after", {31'd0, out_class}, 32'd1);
        chk("s5_latency_after", edges, 32'd3);
        release_result();

        // Scenario 6: reset mid-walk, table kept
        @(negedge clk);
        in_feat  = f1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("s6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("s6_in_ready", {31'd0, in_ready}, 32'd1);
        chk("s6_out_class", {31'd0, out_class}, 32'd0);
        run_walk(f1, edges);
        chk("s6_rerun_latency", edges, 32'd3);
        chk("s6_rerun_class", {31'd0, out_class}, 32'd1);
        chk("s6_rerun_err", {31'd0, out_err}, 32'd0);
        release_result();

        // Feature index past N_FEAT reads as 0: lo branch to N2
        write_node(0, 1'b0, 1'b0, 63, 1, 2);
        run_walk({N_FEAT{1'b1}}, edges);
        chk("oob_latency", edges, 32'd2);
        chk("oob_class", {31'd0, out_class}, 32'd0);
`ifdef DTREE_PATH_EN
        chk("oob_path", {16'd0, out_path}, 32'd0);
`endif
        release_result();

        // Scenario 3: self-loop aborts on the depth guard
        write_node(0, 1'b0, 1'b0, 5, 0, 0);
        run_walk('0, edges);
        chk("s3_latency", edges, 32'd16);
        chk("s3_err", {31'd0, out_err}, 32'd1);
        chk("s3_class", {31'd0, out_class}, 32'd0);
        release_result();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
